// File: rtl/instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_fetch                                                                |
// | Fetch front end: ROM address generation, PC tracking, 2-entry instruction  |
// | buffer with valid/ready to decode, redirect flush of in-flight reads.      |
// | Optional build macro: FETCH_PERF_EN (adds perf_fetched / perf_stall).      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module instr_fetch #(
  parameter int          ADDR_W   = 14,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              fetch_err
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  localparam logic [31:0] c_PC_STEP = 32'd4;

  logic [31:0] r_pc;
  logic        r_inflight;
  logic [31:0] r_inflight_pc;
  logic [31:0] r_fifo_pc    [2];
  logic [31:0] r_fifo_instr [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;
  logic        r_err;

  logic        w_pop;
  logic        w_push;
  logic        w_issue;
  logic [2:0]  w_occupancy;

  assign instr_valid = (r_count != 2'd0);
  assign w_pop       = instr_valid & instr_ready;
  assign w_push      = r_inflight & ~redirect_valid;

  // Slots committed after this edge: buffered words plus the returning read, minus the pop.
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue     = fetch_en & ~r_err & ~redirect_valid & (w_occupancy < 3'd2);

  assign rom_addr  = r_pc[ADDR_W-1:0];
  assign fetch_err = r_err;
  assign instr     = instr_valid ? r_fifo_instr[r_rd_ptr] : 32'h0;
  assign instr_pc  = instr_valid ? r_fifo_pc[r_rd_ptr]    : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'h0;
      r_count       <= 2'd0;
      r_rd_ptr      <= 1'b0;
      r_wr_ptr      <= 1'b0;
      r_err         <= 1'b0;
    end else if (redirect_valid) begin
      // Flush everything; the popped word of this cycle is already owned by decode.
      r_pc       <= redirect_pc;
      r_err      <= |redirect_pc[1:0];
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
        r_pc          <= r_pc + c_PC_STEP;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
      r_fifo_instr[r_wr_ptr] <= rom_data;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= 32'h0;
      perf_stall   <= 32'h0;
    end else begin
      if (w_pop)
        perf_fetched <= perf_fetched + 32'd1;
      if (instr_valid & ~instr_ready & ~redirect_valid)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instr_fetch                                                             |
// | Cycle table plus in-order stream scoreboard for instr_fetch.               |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [13:0] rom_addr;
  logic [31:0] rom_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_err;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(14), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_err      (fetch_err)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  // ROM contents: three test words, a tagged pattern up to 0x28C, zero beyond.
  function automatic logic [31:0] rom_word(input logic [13:0] a);
    if (a == 14'h0)        return 32'h0000_0093;
    else if (a == 14'h4)   return 32'h0000_bf13;
    else if (a == 14'h8)   return 32'h0000_0e93;
    else if (a < 14'h290)  return 32'hA500_0000 | {18'h0, a};
    else                   return 32'h0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rom_data <= 32'h0;
    else        rom_data <= rom_word(rom_addr);
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected in-order stream, refilled on reset / aligned redirect.
  typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;
  exp_t sb_q[$];
  int   m_fetched = 0;
  int   m_stall   = 0;
  bit   mon_en    = 1'b0;

  task automatic push_stream(input logic [31:0] start);
    exp_t e;
    for (int i = 0; i < 48; i++) begin
      e.pc   = start + 32'(4 * i);
      e.word = rom_word(e.pc[13:0]);
      sb_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
`ifdef FETCH_PERF_EN
      chk("perf_fetched", perf_fetched, 32'(m_fetched));
      chk("perf_stall", perf_stall, 32'(m_stall));
`endif
      if (instr_valid && instr_ready) begin
        m_fetched++;
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_unexpected: got pc %h, expected no word", instr_pc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sb_pc", instr_pc, e.pc);
          chk("sb_instr", instr, e.word);
        end
      end else if (instr_valid && !redirect_valid) begin
        m_stall++;
      end
      if (redirect_valid) begin
        sb_q.delete();
        if (redirect_pc[1:0] == 2'b00) push_stream(redirect_pc);
      end
    end
  end

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [13:0] erom;
    logic        eerr;
  } vec_t;

  vec_t tab_a [37];
  vec_t tab_b [10];

  function automatic vec_t mk(input logic fe, input logic rdy, input logic rv,
                              input logic [31:0] rpc, input logic ev, input logic [31:0] epc,
                              input logic [13:0] erom, input logic eerr);
    vec_t v;
    v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.erom = erom; v.eerr = eerr;
    return v;
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, {31'h0, instr_valid}, 32'h0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_instr_pc"}, instr_pc, 32'h0);
    chk({tag, "_rom_addr"}, {18'h0, rom_addr}, 32'h0);
    chk({tag, "_fetch_err"}, {31'h0, fetch_err}, 32'h0);
`ifdef FETCH_PERF_EN
    chk({tag, "_perf_fetched"}, perf_fetched, 32'h0);
    chk({tag, "_perf_stall"}, perf_stall, 32'h0);
`endif
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(posedge clk);
    #1;
    fetch_en       = v.fe;
    instr_ready    = v.rdy;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    @(negedge clk);
    chk($sformatf("c%0d_valid", idx), {31'h0, instr_valid}, {31'h0, v.ev});
    chk($sformatf("c%0d_rom_addr", idx), {18'h0, rom_addr}, {18'h0, v.erom});
    chk($sformatf("c%0d_fetch_err", idx), {31'h0, fetch_err}, {31'h0, v.eerr});
    if (v.ev) begin
      chk($sformatf("c%0d_instr_pc", idx), instr_pc, v.epc);
      chk($sformatf("c%0d_instr", idx), instr, rom_word(v.epc[13:0]));
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb_q.delete();
    push_stream(32'h0);
    mon_en = 1'b1;
    @(negedge clk);
    check_reset_state("reset");
  endtask

  initial begin
    // Run A: streaming, redirect with read in flight, ROM end, misaligned target,
    // fetch_en drop, address wrap.
    tab_a[0]  = mk(1,1,0,0,            0,0,           14'h004,0);
    tab_a[1]  = mk(1,1,0,0,            1,32'h0,       14'h008,0);
    tab_a[2]  = mk(1,1,0,0,            1,32'h4,       14'h00C,0);
    tab_a[3]  = mk(1,1,0,0,            1,32'h8,       14'h010,0);
    tab_a[4]  = mk(1,0,1,32'h270,      1,32'hC,       14'h014,0);
    tab_a[5]  = mk(1,1,0,0,            0,0,           14'h270,0);
    tab_a[6]  = mk(1,1,0,0,            0,0,           14'h274,0);
    tab_a[7]  = mk(1,1,0,0,            1,32'h270,     14'h278,0);
    tab_a[8]  = mk(1,1,0,0,            1,32'h274,     14'h27C,0);
    tab_a[9]  = mk(1,1,0,0,            1,32'h278,     14'h280,0);
    tab_a[10] = mk(1,1,0,0,            1,32'h27C,     14'h284,0);
    tab_a[11] = mk(1,1,0,0,            1,32'h280,     14'h288,0);
    tab_a[12] = mk(1,1,0,0,            1,32'h284,     14'h28C,0);
    tab_a[13] = mk(1,1,0,0,            1,32'h288,     14'h290,0);
    tab_a[14] = mk(1,1,0,0,            1,32'h28C,     14'h294,0);
    tab_a[15] = mk(1,1,0,0,            1,32'h290,     14'h298,0);
    tab_a[16] = mk(1,1,0,0,            1,32'h294,     14'h29C,0);
    tab_a[17] = mk(1,1,1,32'h102,      1,32'h298,     14'h2A0,0);
    tab_a[18] = mk(1,1,0,0,            0,0,           14'h102,1);
    tab_a[19] = mk(1,1,0,0,            0,0,           14'h102,1);
    tab_a[20] = mk(1,1,0,0,            0,0,           14'h102,1);
    tab_a[21] = mk(1,1,1,32'h100,      0,0,           14'h102,1);
    tab_a[22] = mk(1,1,0,0,            0,0,           14'h100,0);
    tab_a[23] = mk(1,1,0,0,            0,0,           14'h104,0);
    tab_a[24] = mk(1,1,0,0,            1,32'h100,     14'h108,0);
    tab_a[25] = mk(1,1,0,0,            1,32'h104,     14'h10C,0);
    tab_a[26] = mk(0,1,0,0,            1,32'h108,     14'h110,0);
    tab_a[27] = mk(0,1,0,0,            1,32'h10C,     14'h110,0);
    tab_a[28] = mk(0,1,0,0,            0,0,           14'h110,0);
    tab_a[29] = mk(1,1,0,0,            0,0,           14'h110,0);
    tab_a[30] = mk(1,1,0,0,            0,0,           14'h114,0);
    tab_a[31] = mk(1,1,0,0,            1,32'h110,     14'h118,0);
    tab_a[32] = mk(1,1,1,32'hFFFF_FFFC,1,32'h114,     14'h11C,0);
    tab_a[33] = mk(1,1,0,0,            0,0,           14'h3FFC,0);
    tab_a[34] = mk(1,1,0,0,            0,0,           14'h000,0);
    tab_a[35] = mk(1,1,0,0,            1,32'hFFFF_FFFC,14'h004,0);
    tab_a[36] = mk(1,1,0,0,            1,32'h0,       14'h008,0);
    // Run B: decode back-pressure for 5 cycles after the first accepted word.
    tab_b[0]  = mk(1,1,0,0,            0,0,           14'h004,0);
    tab_b[1]  = mk(1,1,0,0,            1,32'h0,       14'h008,0);
    tab_b[2]  = mk(1,0,0,0,            1,32'h4,       14'h00C,0);
    tab_b[3]  = mk(1,0,0,0,            1,32'h4,       14'h00C,0);
    tab_b[4]  = mk(1,0,0,0,            1,32'h4,       14'h00C,0);
    tab_b[5]  = mk(1,0,0,0,            1,32'h4,       14'h00C,0);
    tab_b[6]  = mk(1,0,0,0,            1,32'h4,       14'h00C,0);
    tab_b[7]  = mk(1,1,0,0,            1,32'h4,       14'h00C,0);
    tab_b[8]  = mk(1,1,0,0,            1,32'h8,       14'h010,0);
    tab_b[9]  = mk(1,1,0,0,            1,32'hC,       14'h014,0);

    rst_n          = 1'b0;
    fetch_en       = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (3) @(posedge clk);
    release_reset();
    for (int i = 0; i < 37; i++) apply(tab_a[i], i + 1);

    // Asynchronous reset in the middle of a cycle while words are streaming.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    mon_en    = 1'b0;
    m_fetched = 0;
    m_stall   = 0;
    sb_q.delete();
    fetch_en    = 1'b1;
    instr_ready = 1'b1;
    release_reset();
    for (int i = 0; i < 10; i++) apply(tab_b[i], i + 1);

    @(posedge clk);
    #1;
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
